// File: rtl/btn_event_gen_pkg.sv
// Shared definitions for the button event generator: FSM state encoding
// and elaboration-time helpers for the ms prescaler and counter sizing.
package btn_event_gen_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } btn_state_e;

  // Number of clk cycles per millisecond tick.
  function automatic int ms_div(input int clkin_freq);
    return clkin_freq / 1000;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_event_fsm.sv
// Per-button event FSM: edge detection against a registered previous level,
// IDLE/PRESSED/HELD tracking and a ms counter for long-press and auto-repeat.
// BTN_AUTOREPEAT_EN selects whether HELD emits periodic repeat pulses; when
// undefined, HELD simply waits for release with its counter frozen at 0.
module btn_event_fsm
  import btn_event_gen_pkg::*;
#(
  parameter int LONG_PRESS_MS = 500,
  parameter int REPEAT_MS     = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic p,
  input  logic tick,
  output logic btn_held,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int CNT_W = $clog2(max2(LONG_PRESS_MS, REPEAT_MS) + 1);

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             prev_q, prev_d;
  logic             held_q, held_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
`ifdef BTN_AUTOREPEAT_EN
  logic             repeat_q, repeat_d;
`endif

  // Next-state, counter and pulse decode; release takes priority over any tick.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prev_d    = p;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    repeat_d  = 1'b0;
`endif
    cnt_inc   = cnt_q + CNT_W'(1);

    if (!p && prev_q) begin
      release_d = 1'b1;
      state_d   = IDLE;
      cnt_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (p && !prev_q) begin
            press_d = 1'b1;
            cnt_d   = '0;
            state_d = PRESSED;
          end
        end
        PRESSED: begin
          if (tick) begin
            if (cnt_inc == CNT_W'(LONG_PRESS_MS)) begin
              long_d  = 1'b1;
              cnt_d   = '0;
              state_d = HELD;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        HELD: begin
`ifdef BTN_AUTOREPEAT_EN
          if (tick) begin
            if (cnt_inc == CNT_W'(REPEAT_MS)) begin
              repeat_d = 1'b1;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
`else
          cnt_d = '0;
`endif
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    held_d = (state_d != IDLE);
  end

  // State, counter, previous level and registered outputs; prev clears to released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prev_q    <= 1'b0;
      held_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prev_q    <= prev_d;
      held_q    <= held_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  // Auto-repeat pulse register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= repeat_d;
    end
  end

  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = 1'b0;
`endif

  assign btn_held      = held_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;

endmodule

// File: rtl/btn_event_gen.sv
// Button event generator: turns debounced button levels into single-cycle
// press/release/long-press/auto-repeat events. Holds the shared free-running
// ms prescaler and one btn_event_fsm per button.
// Optional feature macro: BTN_AUTOREPEAT_EN (auto-repeat while held).
module btn_event_gen
  import btn_event_gen_pkg::*;
#(
  parameter int CLKIN_FREQ    = 27000000,
  parameter int NUM_BTNS      = 4,
  parameter int ACTIVE_LOW    = 1,
  parameter int LONG_PRESS_MS = 500,
  parameter int REPEAT_MS     = 100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btnIn,
  output logic [NUM_BTNS-1:0] btnHeld,
  output logic [NUM_BTNS-1:0] pressPulse,
  output logic [NUM_BTNS-1:0] releasePulse,
  output logic [NUM_BTNS-1:0] longPress,
  output logic [NUM_BTNS-1:0] repeatPulse
);

  localparam int MS_DIV = ms_div(CLKIN_FREQ);
  localparam int PW     = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

  logic [PW-1:0]       presc_q, presc_d;
  logic                tick;
  logic [NUM_BTNS-1:0] p;

  // Normalise to active-high "pressed".
  assign p = (ACTIVE_LOW != 0) ? ~btnIn : btnIn;

  // Prescaler wrap detection; tick is high for the single cycle at the wrap.
  always_comb begin
    tick    = (presc_q == PW'(MS_DIV - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Free-running ms prescaler, never restarted by button activity.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_event_fsm #(
      .LONG_PRESS_MS (LONG_PRESS_MS),
      .REPEAT_MS     (REPEAT_MS)
    ) u_fsm (
      .clk           (clk),
      .reset         (reset),
      .p             (p[i]),
      .tick          (tick),
      .btn_held      (btnHeld[i]),
      .press_pulse   (pressPulse[i]),
      .release_pulse (releasePulse[i]),
      .long_press    (longPress[i]),
      .repeat_pulse  (repeatPulse[i])
    );
  end

endmodule

// File: tb/tb_btn_event_gen.sv
// Self-checking bench for btn_event_gen: directed vector table, multi-cycle
// corner sequences and randomized clean button levels against a reference
// model based on elapsed ms ticks since each press.
module tb_btn_event_gen;

  localparam int NB     = 4;
  localparam int MS_DIV = 10;
  localparam int LONG   = 5;
  localparam int REP    = 2;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NB-1:0] btnIn = '1;
  logic [NB-1:0] btnHeld, pressPulse, releasePulse, longPress, repeatPulse;

  always #5 clk = ~clk;

  btn_event_gen #(
    .CLKIN_FREQ    (10000),
    .NUM_BTNS      (NB),
    .ACTIVE_LOW    (1),
    .LONG_PRESS_MS (LONG),
    .REPEAT_MS     (REP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btnIn        (btnIn),
    .btnHeld      (btnHeld),
    .pressPulse   (pressPulse),
    .releasePulse (releasePulse),
    .longPress    (longPress),
    .repeatPulse  (repeatPulse)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state
  int            m_edges;
  logic [NB-1:0] m_prev;
  int            m_ticks [NB];
  logic [NB-1:0] e_held, e_press, e_rel, e_long, e_rep;

  typedef struct {
    logic [NB-1:0] btn;
    logic [NB-1:0] held;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
    logic [NB-1:0] lng;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_edges = 0;
    m_prev  = '0;
    for (int b = 0; b < NB; b++) m_ticks[b] = 0;
    e_held = '0; e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
  endtask

  // Expected outputs after the coming clock edge, from ticks elapsed since press.
  task automatic model_edge(input logic [NB-1:0] raw);
    logic [NB-1:0] pr;
    bit tk;
    pr = ~raw;
    tk = ((m_edges + 1) % MS_DIV) == 0;
    m_edges++;
    e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
    for (int b = 0; b < NB; b++) begin
      if (pr[b] && !m_prev[b]) begin
        e_press[b] = 1'b1;
        m_ticks[b] = 0;
      end else if (!pr[b] && m_prev[b]) begin
        e_rel[b] = 1'b1;
      end else if (pr[b] && tk) begin
        m_ticks[b]++;
        if (m_ticks[b] == LONG) e_long[b] = 1'b1;
        else if (REP_EN && m_ticks[b] > LONG && ((m_ticks[b] - LONG) % REP) == 0) e_rep[b] = 1'b1;
      end
    end
    e_held = pr;
    m_prev = pr;
  endtask

  task automatic step(input logic [NB-1:0] raw);
    btnIn = raw;
    model_edge(raw);
    @(posedge clk);
    #1;
    cyc++;
    chk("held",    btnHeld,      e_held);
    chk("press",   pressPulse,   e_press);
    chk("release", releasePulse, e_rel);
    chk("long",    longPress,    e_long);
    chk("repeat",  repeatPulse,  e_rep);
  endtask

  function automatic bit next_is_tick();
    return ((m_edges + 1) % MS_DIV) == 0;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int press_at, rel_at, held_n, long_n, long_at, rep_n, bad_sp, l2, l3, guard;
    logic [NB-1:0] r;

    // Directed vectors starting on the first edges after reset (no tick yet).
    tbl[0] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[1] = '{4'b1110, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    tbl[2] = '{4'b1110, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tbl[3] = '{4'b0010, 4'b1101, 4'b1100, 4'b0000, 4'b0000};
    tbl[4] = '{4'b0011, 4'b1100, 4'b0000, 4'b0001, 4'b0000};
    tbl[5] = '{4'b0011, 4'b1100, 4'b0000, 4'b0000, 4'b0000};
    tbl[6] = '{4'b1111, 4'b0000, 4'b0000, 4'b1100, 4'b0000};
    tbl[7] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

    // Reset state
    model_reset();
    #1;
    chk("rst_held",    btnHeld,      '0);
    chk("rst_press",   pressPulse,   '0);
    chk("rst_release", releasePulse, '0);
    chk("rst_long",    longPress,    '0);
    chk("rst_repeat",  repeatPulse,  '0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].btn);
      chk("tbl_held",    btnHeld,      tbl[i].held);
      chk("tbl_press",   pressPulse,   tbl[i].press);
      chk("tbl_release", releasePulse, tbl[i].rel);
      chk("tbl_long",    longPress,    tbl[i].lng);
    end

    // Tap on button 0 for 20 cycles
    press_at = -1; rel_at = -1; held_n = 0; long_n = 0;
    for (int i = 0; i < 30; i++) begin
      step((i < 20) ? 4'b1110 : 4'b1111);
      if (pressPulse[0])   press_at = i;
      if (releasePulse[0]) rel_at = i;
      if (btnHeld[0])      held_n++;
      if (longPress[0])    long_n++;
    end
    chk_int("tap_press_at", press_at, 0);
    chk_int("tap_release_at", rel_at, 20);
    chk_int("tap_held_cycles", held_n, 20);
    chk_int("tap_no_long", long_n, 0);

    // Long hold on button 1 for 120 cycles
    long_n = 0; long_at = -1; rep_n = 0; bad_sp = 0; rel_at = -1;
    for (int i = 0; i < 140; i++) begin
      step((i < 120) ? 4'b1101 : 4'b1111);
      if (longPress[1]) begin long_n++; long_at = i; end
      if (repeatPulse[1]) begin
        rep_n++;
        if (long_at < 0 || ((i - long_at) % 20) != 0) bad_sp++;
      end
      if (releasePulse[1]) rel_at = i;
    end
    chk_int("hold_long_count", long_n, 1);
    chk_int("hold_long_window", int'(long_at >= 41 && long_at <= 50), 1);
    chk_int("hold_repeat_count", rep_n, REP_EN ? 3 : 0);
    chk_int("hold_repeat_spacing", bad_sp, 0);
    chk_int("hold_release_at", rel_at, 120);

    // Release on the same edge as the 5th tick
    repeat (3) step(4'b1111);
    step(4'b1110);
    long_n = 0; guard = 0;
    while (!(m_ticks[0] == LONG - 1 && next_is_tick()) && guard < 100) begin
      step(4'b1110);
      if (longPress[0]) long_n++;
      guard++;
    end
    chk_int("coinc_align_found", int'(guard < 100), 1);
    step(4'b1111);
    chk("coinc_release", releasePulse, 4'b0001);
    chk("coinc_long", longPress, 4'b0000);
    chk_int("coinc_long_before", long_n, 0);
    repeat (12) step(4'b1111);

    // Reset mid-hold, button still held when reset deasserts
    for (int i = 0; i < 60; i++) step(4'b1110);
    chk("midhold_held", btnHeld, 4'b0001);
    reset = 1'b0;
    model_reset();
    #1;
    chk("arst_held",    btnHeld,      '0);
    chk("arst_press",   pressPulse,   '0);
    chk("arst_release", releasePulse, '0);
    chk("arst_long",    longPress,    '0);
    chk("arst_repeat",  repeatPulse,  '0);
    repeat (3) @(posedge clk);
    #1;
    chk("arst_hold_released", releasePulse, '0);
    reset = 1'b1;
    step(4'b1110);
    chk("rerelease_press", pressPulse, 4'b0001);
    for (int i = 0; i < 10; i++) step(4'b1110);
    step(4'b1111);
    step(4'b1111);

    // Buttons 2 and 3 pressed on the same edge, held for different durations
    l2 = 0; l3 = 0;
    for (int i = 0; i < 80; i++) begin
      r = 4'b0011;
      r[3] = (i >= 30);
      r[2] = (i >= 70);
      step(r);
      if (i == 0) chk("dual_press", pressPulse, 4'b1100);
      if (longPress[2]) l2++;
      if (longPress[3]) l3++;
    end
    chk_int("dual_long2", l2, 1);
    chk_int("dual_long3", l3, 0);

    // Randomized clean levels
    r = 4'b1111;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, 39) == 0) r[b] = ~r[b];
      step(r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
